// File: rtl/apb_master.sv
// apb_master: APB requester. Converts single read/write commands into
// SETUP/ACCESS transfers, waits for the slave's ready (with a timeout), and
// returns read data or a timeout flag as a one-cycle response pulse.
module apb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 8
) (
   input  logic              i_Pclk,
   input  logic              i_Preset,
   input  logic              i_Cmd_Valid,
   output logic              o_Cmd_Ready,
   input  logic              i_Cmd_Write,
   input  logic [ADDR_W-1:0] i_Cmd_Addr,
   input  logic [DATA_W-1:0] i_Cmd_Wdata,
   output logic              o_Psel,
   output logic              o_Penable,
   output logic              o_Pwrite,
   output logic [ADDR_W-1:0] o_Paddr,
   output logic [DATA_W-1:0] o_Pwdata,
   input  logic [DATA_W-1:0] i_Prdata,
   input  logic              i_Pready,
   output logic              o_Rsp_Valid,
   output logic [DATA_W-1:0] o_Rsp_Rdata,
   output logic              o_Rsp_Timeout,
   output logic              o_Busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Wide enough to hold TIMEOUT_CYCLES itself; the count saturates there.
   localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   state_t              state_q,       state_d;
   logic [CNT_W-1:0]    cnt_q,         cnt_d;
   logic                psel_q,        psel_d;
   logic                penable_q,     penable_d;
   logic                pwrite_q,      pwrite_d;
   logic [ADDR_W-1:0]   paddr_q,       paddr_d;
   logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
   logic                rsp_valid_q,   rsp_valid_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
   logic [CNT_W-1:0]    cnt_inc;
   logic                cmd_accept;

   // Ready is decoded from the state register and held low while in reset.
   assign o_Cmd_Ready = (state_q == IDLE) && i_Preset;
   assign cmd_accept  = i_Cmd_Valid && o_Cmd_Ready;
   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // Next-state and registered-output decode for the IDLE/SETUP/ACCESS FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_accept) begin
               pwrite_d = i_Cmd_Write;
               paddr_d  = i_Cmd_Addr;
               if (i_Cmd_Write) pwdata_d = i_Cmd_Wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               cnt_d     = '0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (i_Pready) begin
               // Completion wins over a timeout landing on the same edge.
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : i_Prdata;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_MAX) begin
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  rsp_valid_d   = 1'b1;
                  rsp_timeout_d = 1'b1;
                  rsp_rdata_d   = '0;
                  state_d       = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset may arrive mid-transfer.
   always_ff @(posedge i_Pclk or negedge i_Preset) begin
      if (!i_Preset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_rdata_q   <= rsp_rdata_d;
      end
   end

   assign o_Psel        = psel_q;
   assign o_Penable     = penable_q;
   assign o_Pwrite      = pwrite_q;
   assign o_Paddr       = paddr_q;
   assign o_Pwdata      = pwdata_q;
   assign o_Rsp_Valid   = rsp_valid_q;
   assign o_Rsp_Timeout = rsp_timeout_q;
   assign o_Rsp_Rdata   = rsp_rdata_q;
   assign o_Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master. Stimulus pushes expected
// responses into a scoreboard queue; a monitor pops and compares on every
// o_Rsp_Valid pulse. Transfer shape and timing are checked inline.
module tb_apb_master;

   localparam int TO = 16;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [7:0]  pwdata;
   logic [7:0]  prdata;
   logic        pready;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_timeout;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int setups = 0;

   typedef struct packed {
      logic       timeout;
      logic [7:0] rdata;
   } rsp_t;

   rsp_t sb[$];

   apb_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(32), .DATA_W(8)) dut (
      .i_Pclk       (clk),
      .i_Preset     (rst_n),
      .i_Cmd_Valid  (cmd_valid),
      .o_Cmd_Ready  (cmd_ready),
      .i_Cmd_Write  (cmd_write),
      .i_Cmd_Addr   (cmd_addr),
      .i_Cmd_Wdata  (cmd_wdata),
      .o_Psel       (psel),
      .o_Penable    (penable),
      .o_Pwrite     (pwrite),
      .o_Paddr      (paddr),
      .o_Pwdata     (pwdata),
      .i_Prdata     (prdata),
      .i_Pready     (pready),
      .o_Rsp_Valid  (rsp_valid),
      .o_Rsp_Rdata  (rsp_rdata),
      .o_Rsp_Timeout(rsp_timeout),
      .o_Busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: pops the scoreboard on every completion pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               rsp_t e;
               e = sb.pop_front();
               check("rsp_timeout", rsp_timeout, e.timeout);
               check("rsp_rdata", rsp_rdata, e.rdata);
            end
         end else begin
            check("timeout_idle_zero", rsp_timeout, 1'b0);
         end
      end
   end

   // Counts SETUP phases so double issue is visible.
   always @(negedge clk) begin
      if (rst_n && psel && !penable) setups++;
   end

   // One full transfer: waits = number of low-Pready ACCESS edges before high.
   task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] wd,
                          input int waits, input logic [7:0] rd, input bit exp_to);
      int   acc;
      int   exp_acc;
      bit   done;
      rsp_t e;
      e.timeout = exp_to;
      e.rdata   = (exp_to || wr) ? 8'h00 : rd;
      sb.push_back(e);
      exp_acc = exp_to ? TO : waits + 1;

      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      prdata    = rd;
      pready    = 1'b1;   // high in IDLE/SETUP: must be ignored there
      @(negedge clk);
      check("setup_psel", psel, 1'b1);
      check("setup_penable", penable, 1'b0);
      check("setup_paddr", paddr, addr);
      check("setup_pwrite", pwrite, wr);
      check("setup_ready", cmd_ready, 1'b0);
      check("setup_busy", busy, 1'b1);
      if (wr) check("setup_pwdata", pwdata, wd);
      cmd_valid = 1'b0;
      cmd_write = ~wr;
      cmd_addr  = 32'hDEAD_BEEF;
      cmd_wdata = 8'hEE;

      acc  = 0;
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (!psel) begin
            done = 1'b1;
         end else begin
            acc++;
            check("access_penable", penable, 1'b1);
            check("access_paddr", paddr, addr);
            pready = (acc > waits);
         end
      end
      check("xfer_completed", done, 1'b1);
      check("access_cycles", acc, exp_acc);
      check("done_penable", penable, 1'b0);
      check("done_rsp_valid", rsp_valid, 1'b1);
      check("done_ready", cmd_ready, 1'b1);
      check("done_busy", busy, 1'b0);
      pready = 1'b0;
      @(negedge clk);
      check("post_rsp_valid", rsp_valid, 1'b0);
      check("post_rdata_hold", rsp_rdata, e.rdata);
   endtask

   initial begin
      int s0;
      rsp_t e;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      prdata    = '0;
      pready    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_psel", psel, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_ready", cmd_ready, 1'b1);
      check("rst_paddr", paddr, 32'h0);

      // Write, immediate ready.
      run_cmd(1'b1, 32'h0000_0004, 8'hA5, 0, 8'h00, 1'b0);
      // Read, five wait cycles then 0x3C.
      run_cmd(1'b0, 32'h0000_0008, 8'h00, 5, 8'h3C, 1'b0);
      check("read_keeps_pwdata", pwdata, 8'hA5);
      // Read with ready stuck low: timeout.
      run_cmd(1'b0, 32'h0000_000C, 8'h00, 1000, 8'h99, 1'b1);
      check("timeout_psel", psel, 1'b0);
      // Ready rises on the 16th ACCESS edge: normal completion.
      run_cmd(1'b0, 32'h0000_0010, 8'h00, TO - 1, 8'h5A, 1'b0);

      // Back-to-back with Valid held high: write 0x11 then read.
      s0 = setups;
      e.timeout = 1'b0; e.rdata = 8'h00; sb.push_back(e);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = 8'h11;
      pready = 1'b1; prdata = 8'h77;
      @(negedge clk);                                  // after E0
      check("b2b_w_paddr", paddr, 32'h0000_0020);
      check("b2b_w_pwdata", pwdata, 8'h11);
      e.timeout = 1'b0; e.rdata = 8'h77; sb.push_back(e);
      cmd_write = 1'b0; cmd_addr = 32'h0000_0024; cmd_wdata = 8'hCC;
      @(negedge clk);                                  // after E1
      check("b2b_w_access", penable, 1'b1);
      check("b2b_w_paddr_hold", paddr, 32'h0000_0020);
      @(negedge clk);                                  // after E2
      check("b2b_rsp1", rsp_valid, 1'b1);
      check("b2b_ready_on_rsp", cmd_ready, 1'b1);
      @(negedge clk);                                  // after E3
      check("b2b_r_setup", {psel, penable}, 2'b10);
      check("b2b_r_paddr", paddr, 32'h0000_0024);
      check("b2b_r_pwrite", pwrite, 1'b0);
      check("b2b_r_pwdata_kept", pwdata, 8'h11);
      cmd_valid = 1'b0;
      @(negedge clk);                                  // after E4
      @(negedge clk);                                  // after E5
      check("b2b_rsp2", rsp_valid, 1'b1);
      @(negedge clk);
      check("b2b_no_reissue", psel, 1'b0);
      check("b2b_setups", setups - s0, 2);

      // Reset in the middle of ACCESS.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030; pready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_rst_access", {psel, penable}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_psel", psel, 1'b0);
      check("mid_rst_penable", penable, 1'b0);
      check("mid_rst_rsp_valid", rsp_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1'b1);
      check("post_rst_psel", psel, 1'b0);
      repeat (3) @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 1'b0);

      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
